note_sequencer: RTL and testbench

//  Plays a melody stored in an internal note table and feeds the square-wave tone stage directly downstream,
//  one command (half-period, volume) per note over a valid/ready handshake. Holds each note for a programmed

---
 rtl/note_sequencer.sv | 170 +++++++++++++++++
 tb/tb_note_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/note_sequencer.sv
// Melody sequencer: walks a loadable note table and hands one (half-period, volume)
// command per note to the tone stage over valid/ready, holding each note for its duration.
module note_sequencer #(
    parameter int DEPTH    = 32,
    parameter int TICK_DIV = 25000,
    parameter int LOOP     = 0
) (
    input  logic                     i_Clk,
    input  logic                     i_Reset,
    input  logic                     i_Start,
    input  logic                     i_Stop,
    input  logic                     i_Wr_En,
    input  logic [$clog2(DEPTH)-1:0] i_Wr_Addr,
    input  logic [26:0]              i_Wr_Data,
    output logic [15:0]              o_Half_Period,
    output logic [2:0]               o_Volume,
    output logic                     o_Valid,
    input  logic                     i_Ready,
    output logic                     o_Busy,
    output logic                     o_Done
);

    localparam int ADDR_W  = $clog2(DEPTH);
    localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
    localparam logic [ADDR_W:0]    PTR_ONE    = (ADDR_W + 1)'(1);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_READ    = 3'd1;
    localparam logic [2:0] ST_ISSUE   = 3'd2;
    localparam logic [2:0] ST_HOLD    = 3'd3;
    localparam logic [2:0] ST_SILENCE = 3'd4;

    logic [26:0]        r_Mem [DEPTH];
    logic [26:0]        r_Rd_Data;
    logic [2:0]         r_State;
    logic [ADDR_W:0]    r_Ptr;
    logic [PRESC_W-1:0] r_Presc;
    logic [7:0]         r_Dur;

    logic [2:0]         w_State_Next;
    logic [ADDR_W:0]    w_Ptr_Next;
    logic               w_Wr_Ok;
    logic               w_End;
    logic               w_Hold_Last;
    logic [2:0]         w_Ent_Vol;
    logic [15:0]        w_Ent_Hp;
    logic [7:0]         w_Ent_Dur;

    assign o_Busy      = (r_State != ST_IDLE);
    assign w_Wr_Ok     = i_Wr_En && !o_Busy && !i_Reset;
    assign w_Ent_Vol   = r_Rd_Data[26:24];
    assign w_Ent_Hp    = r_Rd_Data[23:8];
    assign w_Ent_Dur   = r_Rd_Data[7:0];
    assign w_End       = r_Ptr[ADDR_W] || (w_Ent_Dur == 8'd0);
    assign w_Hold_Last = (r_Presc == PRESC_LAST) && (r_Dur == 8'd1);

    always_ff @(posedge i_Clk) begin
        if (w_Wr_Ok) begin
            r_Mem[i_Wr_Addr] <= i_Wr_Data;
        end
    end

    // Read is addressed by the next pointer so the entry is ready during READ;
    // a write to that address in the same cycle is forwarded.
    always_ff @(posedge i_Clk) begin
        if (w_Wr_Ok && (i_Wr_Addr == w_Ptr_Next[ADDR_W-1:0])) begin
            r_Rd_Data <= i_Wr_Data;
        end else begin
            r_Rd_Data <= r_Mem[w_Ptr_Next[ADDR_W-1:0]];
        end
    end

    always_comb begin
        w_State_Next = r_State;
        w_Ptr_Next   = r_Ptr;
        case (r_State)
            ST_IDLE: begin
                if (i_Start && !i_Stop) begin
                    w_State_Next = ST_READ;
                    w_Ptr_Next   = '0;
                end
            end
            ST_READ: begin
                if (i_Stop) begin
                    w_State_Next = ST_SILENCE;
                end else if (w_End) begin
                    if ((LOOP != 0) && (r_Ptr != '0)) begin
                        w_State_Next = ST_READ;
                        w_Ptr_Next   = '0;
                    end else begin
                        w_State_Next = ST_SILENCE;
                    end
                end else begin
                    w_State_Next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (i_Stop) begin
                    w_State_Next = ST_SILENCE;
                end else if (i_Ready) begin
                    w_State_Next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (i_Stop) begin
                    w_State_Next = ST_SILENCE;
                end else if (w_Hold_Last) begin
                    w_State_Next = ST_READ;
                    w_Ptr_Next   = r_Ptr + PTR_ONE;
                end
            end
            ST_SILENCE: begin
                if (i_Ready) begin
                    w_State_Next = ST_IDLE;
                    w_Ptr_Next   = '0;
                end
            end
            default: begin
                w_State_Next = ST_IDLE;
                w_Ptr_Next   = '0;
            end
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_State       <= ST_IDLE;
            r_Ptr         <= '0;
            r_Presc       <= '0;
            r_Dur         <= '0;
            o_Valid       <= 1'b0;
            o_Done        <= 1'b0;
            o_Half_Period <= '0;
            o_Volume      <= '0;
        end else begin
            r_State <= w_State_Next;
            r_Ptr   <= w_Ptr_Next;
            o_Done  <= 1'b0;

            if (r_State == ST_HOLD) begin
                if (r_Presc == PRESC_LAST) begin
                    r_Presc <= '0;
                    r_Dur   <= r_Dur - 8'd1;
                end else begin
                    r_Presc <= r_Presc + 1'b1;
                end
            end

            if ((w_State_Next == ST_SILENCE) && (r_State != ST_SILENCE)) begin
                o_Valid       <= 1'b1;
                o_Half_Period <= '0;
                o_Volume      <= '0;
            end else if ((r_State == ST_READ) && (w_State_Next == ST_ISSUE)) begin
                o_Valid       <= 1'b1;
                o_Half_Period <= w_Ent_Hp;
                o_Volume      <= (w_Ent_Hp == 16'd0) ? 3'd0 : w_Ent_Vol;
                r_Dur         <= w_Ent_Dur;
            end else if ((r_State == ST_ISSUE) && (w_State_Next == ST_HOLD)) begin
                o_Valid <= 1'b0;
                r_Presc <= '0;
            end else if ((r_State == ST_SILENCE) && (w_State_Next == ST_IDLE)) begin
                o_Valid <= 1'b0;
                o_Done  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_note_sequencer.sv
// Scoreboard bench for note_sequencer: one LOOP=0 and one LOOP=1 instance (DEPTH=8, TICK_DIV=4);
// expected commands are queued by the stimulus and checked by a monitor on every transfer.
module tb_note_sequencer;

    typedef struct {
        logic [15:0] hp;
        logic [2:0]  vol;
        int          gap;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start [2];
    logic        stop  [2];
    logic        wr_en [2];
    logic        rdy   [2];
    logic [2:0]  wr_addr;
    logic [26:0] wr_data;
    logic [15:0] hp    [2];
    logic [2:0]  vol   [2];
    logic        v     [2];
    logic        busy  [2];
    logic        done  [2];

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t q0[$];
    exp_t q1[$];

    int          start_cyc [2];
    int          last_xfer [2];
    int          rise_cyc  [2];
    logic [15:0] cap_hp    [2];
    logic [2:0]  cap_vol   [2];
    logic        pv        [2];
    logic        px        [2];
    logic        prst;
    int          rises     [2];
    int          xfers     [2];
    int          done_cnt  [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    note_sequencer #(.DEPTH(8), .TICK_DIV(4), .LOOP(0)) u_dut0 (
        .i_Clk(clk), .i_Reset(rst), .i_Start(start[0]), .i_Stop(stop[0]),
        .i_Wr_En(wr_en[0]), .i_Wr_Addr(wr_addr), .i_Wr_Data(wr_data),
        .o_Half_Period(hp[0]), .o_Volume(vol[0]), .o_Valid(v[0]), .i_Ready(rdy[0]),
        .o_Busy(busy[0]), .o_Done(done[0])
    );

    note_sequencer #(.DEPTH(8), .TICK_DIV(4), .LOOP(1)) u_dut1 (
        .i_Clk(clk), .i_Reset(rst), .i_Start(start[1]), .i_Stop(stop[1]),
        .i_Wr_En(wr_en[1]), .i_Wr_Addr(wr_addr), .i_Wr_Data(wr_data),
        .o_Half_Period(hp[1]), .o_Volume(vol[1]), .o_Valid(v[1]), .i_Ready(rdy[1]),
        .o_Busy(busy[1]), .o_Done(done[1])
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int qsize(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    task automatic push(input int d, input logic [15:0] h, input logic [2:0] vl, input int gap);
        exp_t e;
        e.hp = h; e.vol = vl; e.gap = gap;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input int d, input int addr, input logic [2:0] vl,
                      input logic [15:0] h, input logic [7:0] dur);
        wr_en[d] = 1'b1;
        wr_addr  = 3'(addr);
        wr_data  = {vl, h, dur};
        tick(1);
        wr_en[d] = 1'b0;
    endtask

    task automatic pulse_start(input int d);
        start[d]     = 1'b1;
        start_cyc[d] = cyc;
        tick(1);
        start[d]     = 1'b0;
    endtask

    task automatic pulse_stop(input int d);
        stop[d] = 1'b1;
        tick(1);
        stop[d] = 1'b0;
    endtask

    task automatic wait_idle(input int d);
        int n = 0;
        while ((busy[d] || qsize(d) != 0) && n < 300) begin
            tick(1);
            n++;
        end
        if (n >= 300) chk("idle_timeout", 1, 0);
        tick(2);
    endtask

    task automatic load_song1();
        wr(0, 0, 3'd3, 16'd1000, 8'd2);
        wr(0, 1, 3'd5, 16'd500,  8'd1);
        wr(0, 2, 3'd0, 16'd0,    8'd0);
    endtask

    task automatic push_song1();
        push(0, 16'd1000, 3'd3, 2);
        push(0, 16'd500,  3'd5, 10);
        push(0, 16'd0,    3'd0, 6);
    endtask

    task automatic monitor();
        exp_t e;
        int   ref_c;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (v[d] && !pv[d]) begin
                    rise_cyc[d] = cyc;
                    cap_hp[d]   = hp[d];
                    cap_vol[d]  = vol[d];
                    rises[d]++;
                end
                if (!v[d] && pv[d]) chk("valid_withdrawn", int'(px[d] || prst), 1);
                px[d] = 1'b0;
                if (v[d] && rdy[d]) begin
                    px[d] = 1'b1;
                    xfers[d]++;
                    if (qsize(d) == 0) begin
                        chk("unexpected_cmd", int'(hp[d]), -1);
                    end else begin
                        if (d == 0) e = q0.pop_front();
                        else        e = q1.pop_front();
                        chk($sformatf("dut%0d_half_period", d), int'(hp[d]), int'(e.hp));
                        chk($sformatf("dut%0d_volume", d), int'(vol[d]), int'(e.vol));
                        if (cyc != rise_cyc[d]) begin
                            chk("stall_hp_stable", int'(hp[d]), int'(cap_hp[d]));
                            chk("stall_vol_stable", int'(vol[d]), int'(cap_vol[d]));
                        end
                        if (e.gap >= 0) begin
                            ref_c = (start_cyc[d] > last_xfer[d]) ? start_cyc[d] : last_xfer[d];
                            chk($sformatf("dut%0d_issue_gap", d), rise_cyc[d] - ref_c, e.gap);
                        end
                    end
                    last_xfer[d] = cyc;
                end
                if (done[d]) done_cnt[d]++;
                pv[d] = v[d];
            end
            prst = rst;
        end
    endtask

    initial begin
        int dc;
        int r0;
        int tgt;
        int n;

        rst = 1'b1;
        wr_addr = '0;
        wr_data = '0;
        prst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            start[d] = 1'b0; stop[d] = 1'b0; wr_en[d] = 1'b0; rdy[d] = 1'b1;
            start_cyc[d] = -100; last_xfer[d] = -100; rise_cyc[d] = 0;
            cap_hp[d] = '0; cap_vol[d] = '0; pv[d] = 1'b0; px[d] = 1'b0;
            rises[d] = 0; xfers[d] = 0; done_cnt[d] = 0;
        end
        fork
            monitor();
        join_none

        tick(3);
        for (int d = 0; d < 2; d++) begin
            chk("rst_valid", int'(v[d]), 0);
            chk("rst_busy", int'(busy[d]), 0);
            chk("rst_done", int'(done[d]), 0);
            chk("rst_hp", int'(hp[d]), 0);
            chk("rst_vol", int'(vol[d]), 0);
        end
        rst = 1'b0;
        tick(1);

        // Basic song, ready always high.
        load_song1();
        push_song1();
        dc = done_cnt[0];
        pulse_start(0);
        wait_idle(0);
        chk("song1_done", done_cnt[0] - dc, 1);
        chk("song1_busy", int'(busy[0]), 0);

        // Ready held low for 10 cycles on the first command.
        push_song1();
        rdy[0] = 1'b0;
        pulse_start(0);
        tick(11);
        rdy[0] = 1'b1;
        wait_idle(0);

        // Rest entry; entry 0 written in the same cycle as the start.
        wr(0, 1, 3'd7, 16'd0,   8'd1);
        wr(0, 2, 3'd4, 16'd300, 8'd1);
        wr(0, 3, 3'd0, 16'd0,   8'd0);
        push(0, 16'd700, 3'd2, 2);
        push(0, 16'd0,   3'd0, 6);
        push(0, 16'd300, 3'd4, 6);
        push(0, 16'd0,   3'd0, 6);
        wr_en[0] = 1'b1; wr_addr = 3'd0; wr_data = {3'd2, 16'd700, 8'd1};
        pulse_start(0);
        wr_en[0] = 1'b0;
        wait_idle(0);

        // Start and stop together while idle.
        r0 = rises[0];
        dc = done_cnt[0];
        start[0] = 1'b1; stop[0] = 1'b1;
        tick(1);
        start[0] = 1'b0; stop[0] = 1'b0;
        chk("startstop_busy", int'(busy[0]), 0);
        tick(6);
        chk("startstop_cmds", rises[0] - r0, 0);
        chk("startstop_done", done_cnt[0] - dc, 0);

        // Stop in the middle of the first hold.
        load_song1();
        push(0, 16'd1000, 3'd3, 2);
        push(0, 16'd0,    3'd0, 4);
        dc = done_cnt[0];
        pulse_start(0);
        tick(4);
        pulse_stop(0);
        wait_idle(0);
        chk("stop_done", done_cnt[0] - dc, 1);

        // Reset while a command is pending.
        rdy[0] = 1'b0;
        pulse_start(0);
        tick(1);
        chk("pre_reset_valid", int'(v[0]), 1);
        rst = 1'b1;
        tick(1);
        chk("mid_rst_valid", int'(v[0]), 0);
        chk("mid_rst_busy", int'(busy[0]), 0);
        chk("mid_rst_hp", int'(hp[0]), 0);
        chk("mid_rst_vol", int'(vol[0]), 0);
        chk("mid_rst_done", int'(done[0]), 0);
        rst = 1'b0;
        rdy[0] = 1'b1;
        tick(1);

        // Table survives reset; writes while busy are dropped.
        push_song1();
        dc = done_cnt[0];
        pulse_start(0);
        wr(0, 1, 3'd1, 16'd1234, 8'd3);
        wait_idle(0);
        chk("replay_done", done_cnt[0] - dc, 1);

        // LOOP=1: all eight entries, wrap back to entry 0, then stop.
        for (int i = 0; i < 8; i++) begin
            wr(1, i, 3'(i + 1), 16'(100 * (i + 1)), 8'd1);
            push(1, 16'(100 * (i + 1)), 3'(i + 1), (i == 0) ? 2 : 6);
        end
        push(1, 16'd100, 3'd1, 7);
        push(1, 16'd0,   3'd0, 2);
        dc  = done_cnt[1];
        tgt = xfers[1] + 9;
        pulse_start(1);
        n = 0;
        while (xfers[1] < tgt && n < 200) begin
            tick(1);
            n++;
        end
        if (n >= 200) chk("loop_timeout", 1, 0);
        chk("loop_no_done", done_cnt[1] - dc, 0);
        pulse_stop(1);
        wait_idle(1);
        chk("loop_stop_done", done_cnt[1] - dc, 1);

        // LOOP=1 with end marker at entry 0: silence only.
        wr(1, 0, 3'd0, 16'd0, 8'd0);
        push(1, 16'd0, 3'd0, 2);
        dc = done_cnt[1];
        r0 = rises[1];
        pulse_start(1);
        wait_idle(1);
        chk("empty_done", done_cnt[1] - dc, 1);
        chk("empty_cmds", rises[1] - r0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
